fm_seq_checker: RTL

- Synthesizable hardware checker for the property first_match(A ##1 B[*MIN_REPS:$] ##1 C) |=> D.
- Sits beside the trace sequencer in the SVA regression benches. Gives a cycle-exact reference model that formal results are compared against.
- Runs overlapping attempts in parallel, applies first-match semantics per attempt, and reports failures, counts and busy status to the bench controller.

---
 rtl/fm_seq_pkg.sv | 21 ++
 rtl/fm_seq_checker.sv | 80 ++++++++
 2 files changed

// File: rtl/fm_seq_pkg.sv
// Shared types and helpers for the first_match(A ##1 B[*N:$] ##1 C) |=> D checker.
// Imported by the checker RTL and by benches that collect its status.
package fm_seq_pkg;

  localparam int MAX_MIN_REPS = 7;

  typedef struct packed {
    logic match;
    logic fail;
    logic fail_sticky;
    logic busy;
  } fm_status_t;

  // Saturating increment; max_val is the all-ones value of the caller's counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    sat_inc = (inc && (val != max_val)) ? (val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/fm_seq_checker.sv
// Cycle-exact checker for first_match(A ##1 B[*MIN_REPS:$] ##1 C) |=> D with merged
// per-repetition thread bits, a one-deep obligation and saturating match/fail counters.
module fm_seq_checker
  import fm_seq_pkg::*;
#(
  parameter int MIN_REPS = 0,
  parameter int CW       = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          en,
  input  logic          clear,
  input  logic          a,
  input  logic          b,
  input  logic          c,
  input  logic          d,
  output logic          match,
  output logic          fail,
  output logic          fail_sticky,
  output logic          busy,
  output logic [CW-1:0] match_count,
  output logic [CW-1:0] fail_count
);

  localparam int R = (MIN_REPS > MAX_MIN_REPS) ? MAX_MIN_REPS : MIN_REPS;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [R:0]    w_q, w_d;
  logic          oblig_q;
  logic          match_q, fail_q, sticky_q;
  logic [CW-1:0] match_cnt_q, fail_cnt_q;
  logic          hit, viol;

  // Only the saturated stage can complete; c in earlier stages is not yet a match.
  assign hit  = w_q[R] & c;
  assign viol = oblig_q & ~d;

  generate
    if (R == 0) begin : g_zero
      assign w_d[0] = a | (w_q[0] & b & ~c);
    end else begin : g_reps
      assign w_d[0] = a;
      for (genvar gi = 0; gi < R - 1; gi++) begin : g_mid
        assign w_d[gi+1] = w_q[gi] & b;
      end
      assign w_d[R] = (w_q[R-1] & b) | (w_q[R] & b & ~c);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      w_q         <= '0;
      oblig_q     <= 1'b0;
      match_q     <= 1'b0;
      fail_q      <= 1'b0;
      sticky_q    <= 1'b0;
      match_cnt_q <= '0;
      fail_cnt_q  <= '0;
    end else if (en) begin
      w_q         <= w_d;
      oblig_q     <= hit;
      match_q     <= hit;
      fail_q      <= viol;
      sticky_q    <= sticky_q | viol;
      match_cnt_q <= CW'(sat_inc(32'(match_cnt_q), 32'(CNT_MAX), hit));
      fail_cnt_q  <= CW'(sat_inc(32'(fail_cnt_q), 32'(CNT_MAX), viol));
    end else begin
      match_q <= 1'b0;
      fail_q  <= 1'b0;
    end
  end

  assign match       = match_q;
  assign fail        = fail_q;
  assign fail_sticky = sticky_q;
  assign busy        = (|w_q) | oblig_q;
  assign match_count = match_cnt_q;
  assign fail_count  = fail_cnt_q;

endmodule
